// File: rtl/aurora_hls_nfc_ctrl.sv
// Native-flow-control generator for the Aurora RX path.
// Watches the RX FIFO fill level against hysteresis thresholds and emits
// XOFF/XON words on the NFC AXI-Stream port. It can re-send XOFF periodically
// while paused. Saturating handshake counters and a high-water mark of the
// fill level are kept alongside.
module aurora_hls_nfc_ctrl #(
    parameter int unsigned LEVEL_WIDTH    = 10,
    parameter int unsigned FULL_THRESH    = 768,
    parameter int unsigned EMPTY_THRESH   = 256,
    parameter logic [15:0] XOFF_CODE      = 16'hFFFF,
    parameter logic [15:0] XON_CODE       = 16'h0000,
    parameter int unsigned REFRESH_CYCLES = 0,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [LEVEL_WIDTH-1:0] fifo_rx_level,
    input  logic                   s_axi_nfc_tready,
    output logic                   s_axi_nfc_tvalid,
    output logic [15:0]            s_axi_nfc_tdata,
    output logic                   paused,
    input  logic                   clear_stats,
    output logic [CNT_WIDTH-1:0]   xoff_count,
    output logic [CNT_WIDTH-1:0]   xon_count,
    output logic [LEVEL_WIDTH-1:0] level_max
);

    generate
        if (EMPTY_THRESH >= FULL_THRESH) begin : g_bad_thresh
            $error("aurora_hls_nfc_ctrl: EMPTY_THRESH must be strictly below FULL_THRESH");
        end
    endgenerate

    localparam logic [LEVEL_WIDTH-1:0] FULL_LVL  = LEVEL_WIDTH'(FULL_THRESH);
    localparam logic [LEVEL_WIDTH-1:0] EMPTY_LVL = LEVEL_WIDTH'(EMPTY_THRESH);

    // The timer only has to reach REFRESH_CYCLES-1, so clog2 of the period suffices.
    localparam int unsigned          TIMER_W      = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit                   REFRESH_EN   = (REFRESH_CYCLES != 0);
    localparam logic [TIMER_W-1:0]   REFRESH_LAST = REFRESH_EN ? TIMER_W'(REFRESH_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        FLOWING   = 2'd0,
        XOFF_SEND = 2'd1,
        PAUSED    = 2'd2,
        XON_SEND  = 2'd3
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               xoff_done;
    logic               xon_done;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A message is complete when the core accepts the word we are holding.
    assign xoff_done = (state == XOFF_SEND) && s_axi_nfc_tready;
    assign xon_done  = (state == XON_SEND)  && s_axi_nfc_tready;

    // Flow-control FSM; tvalid/tdata/paused are registered here, and a word once
    // raised is held until it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= FLOWING;
            timer            <= '0;
            s_axi_nfc_tvalid <= 1'b0;
            s_axi_nfc_tdata  <= 16'h0000;
            paused           <= 1'b0;
        end else begin
            case (state)
                FLOWING: begin
                    if (enable && (fifo_rx_level >= FULL_LVL)) begin
                        s_axi_nfc_tdata  <= XOFF_CODE;
                        s_axi_nfc_tvalid <= 1'b1;
                        state            <= XOFF_SEND;
                    end
                end
                XOFF_SEND: begin
                    if (s_axi_nfc_tready) begin
                        s_axi_nfc_tvalid <= 1'b0;
                        paused           <= 1'b1;
                        timer            <= '0;
                        state            <= PAUSED;
                    end
                end
                PAUSED: begin
                    // Release wins over refresh when both fall in the same cycle.
                    if (!enable || (fifo_rx_level <= EMPTY_LVL)) begin
                        s_axi_nfc_tdata  <= XON_CODE;
                        s_axi_nfc_tvalid <= 1'b1;
                        state            <= XON_SEND;
                    end else if (REFRESH_EN && (timer == REFRESH_LAST)) begin
                        s_axi_nfc_tdata  <= XOFF_CODE;
                        s_axi_nfc_tvalid <= 1'b1;
                        state            <= XOFF_SEND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                XON_SEND: begin
                    if (s_axi_nfc_tready) begin
                        s_axi_nfc_tvalid <= 1'b0;
                        paused           <= 1'b0;
                        state            <= FLOWING;
                    end
                end
                default: state <= FLOWING;
            endcase
        end
    end

    // XOFF handshake counter; a clear coinciding with a handshake leaves 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xoff_count <= '0;
        end else if (clear_stats) begin
            xoff_count <= xoff_done ? CNT_WIDTH'(1) : '0;
        end else if (xoff_done) begin
            xoff_count <= sat_inc(xoff_count);
        end
    end

    // XON handshake counter; same clear/increment interaction as XOFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xon_count <= '0;
        end else if (clear_stats) begin
            xon_count <= xon_done ? CNT_WIDTH'(1) : '0;
        end else if (xon_done) begin
            xon_count <= sat_inc(xon_count);
        end
    end

    // High-water mark of the FIFO level; a clear restarts it from the current level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_max <= '0;
        end else if (clear_stats || (fifo_rx_level > level_max)) begin
            level_max <= fifo_rx_level;
        end
    end

endmodule

// File: tb/tb_aurora_hls_nfc_ctrl.sv
// Directed bench for aurora_hls_nfc_ctrl: a table of per-cycle vectors plus
// hand-written sequences for clear/saturation and reset mid-handshake.
module tb_aurora_hls_nfc_ctrl;

    localparam int LW = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [LW-1:0] fifo_rx_level;
    logic          s_axi_nfc_tready;
    logic          s_axi_nfc_tvalid;
    logic [15:0]   s_axi_nfc_tdata;
    logic          paused;
    logic          clear_stats;
    logic [CW-1:0] xoff_count;
    logic [CW-1:0] xon_count;
    logic [LW-1:0] level_max;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aurora_hls_nfc_ctrl #(
        .LEVEL_WIDTH   (LW),
        .FULL_THRESH   (768),
        .EMPTY_THRESH  (256),
        .XOFF_CODE     (16'hFFFF),
        .XON_CODE      (16'h0000),
        .REFRESH_CYCLES(16),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .fifo_rx_level   (fifo_rx_level),
        .s_axi_nfc_tready(s_axi_nfc_tready),
        .s_axi_nfc_tvalid(s_axi_nfc_tvalid),
        .s_axi_nfc_tdata (s_axi_nfc_tdata),
        .paused          (paused),
        .clear_stats     (clear_stats),
        .xoff_count      (xoff_count),
        .xon_count       (xon_count),
        .level_max       (level_max)
    );

    typedef struct {
        logic          en;
        logic [LW-1:0] lvl;
        logic          rdy;
        logic          clr;
        logic          vld;
        logic [15:0]   data;
        logic          psd;
        logic [CW-1:0] xoff;
        logic [CW-1:0] xon;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input int lvl, input logic rdy, input logic clr,
                       input logic vld, input logic [15:0] data, input logic psd,
                       input int xoff, input int xon);
        vec_t v;
        v.en   = en;
        v.lvl  = LW'(lvl);
        v.rdy  = rdy;
        v.clr  = clr;
        v.vld  = vld;
        v.data = data;
        v.psd  = psd;
        v.xoff = CW'(xoff);
        v.xon  = CW'(xon);
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input int lvl, input logic rdy, input logic clr);
        enable           = en;
        fifo_rx_level    = LW'(lvl);
        s_axi_nfc_tready = rdy;
        clear_stats      = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, with a high level present to show nothing leaks out.
        rst_n = 1'b0;
        drive(1'b1, 900, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset tvalid", 32'(s_axi_nfc_tvalid), 32'd0);
        chk("reset tdata", 32'(s_axi_nfc_tdata), 32'd0);
        chk("reset paused", 32'(paused), 32'd0);
        chk("reset xoff_count", 32'(xoff_count), 32'd0);
        chk("reset xon_count", 32'(xon_count), 32'd0);
        chk("reset level_max", 32'(level_max), 32'd0);
        @(negedge clk);
        drive(1'b1, 0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Ramp up, XOFF at 768, hysteresis band, XON at 256.
        add(1, 0,    1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 400,  1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 767,  1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 768,  1, 0, 1, 16'hFFFF, 0, 0, 0);
        add(1, 800,  1, 0, 0, 16'hFFFF, 1, 1, 0);
        add(1, 800,  1, 0, 0, 16'hFFFF, 1, 1, 0);
        add(1, 500,  1, 0, 0, 16'hFFFF, 1, 1, 0);
        add(1, 257,  1, 0, 0, 16'hFFFF, 1, 1, 0);
        add(1, 256,  1, 0, 1, 16'h0000, 1, 1, 0);
        add(1, 256,  1, 0, 0, 16'h0000, 0, 1, 1);
        add(1, 256,  1, 0, 0, 16'h0000, 0, 1, 1);
        // XOFF stalled by tready low for 5 cycles, accepted on the 6th.
        add(1, 900,  0, 0, 1, 16'hFFFF, 0, 1, 1);
        for (int k = 0; k < 5; k++) add(1, 900, 0, 0, 1, 16'hFFFF, 0, 1, 1);
        add(1, 900,  1, 0, 0, 16'hFFFF, 1, 2, 1);
        // XON stalled while level swings back up; it still completes.
        add(1, 100,  0, 0, 1, 16'h0000, 1, 2, 1);
        add(1, 900,  0, 0, 1, 16'h0000, 1, 2, 1);
        add(1, 900,  1, 0, 0, 16'h0000, 0, 2, 2);
        add(1, 900,  1, 0, 1, 16'hFFFF, 0, 2, 2);
        add(1, 100,  1, 0, 0, 16'hFFFF, 1, 3, 2);
        add(1, 100,  1, 0, 1, 16'h0000, 1, 3, 2);
        add(1, 100,  1, 0, 0, 16'h0000, 0, 3, 3);
        // Enable handling: no XOFF while disabled, XOFF completes then XON.
        add(0, 1000, 1, 0, 0, 16'h0000, 0, 3, 3);
        add(1, 1000, 1, 0, 1, 16'hFFFF, 0, 3, 3);
        add(0, 1000, 1, 0, 0, 16'hFFFF, 1, 4, 3);
        add(0, 1000, 1, 0, 1, 16'h0000, 1, 4, 3);
        add(0, 1000, 1, 0, 0, 16'h0000, 0, 4, 4);
        add(0, 1000, 1, 0, 0, 16'h0000, 0, 4, 4);
        add(0, 1000, 1, 0, 0, 16'h0000, 0, 4, 4);
        add(1, 1000, 1, 0, 1, 16'hFFFF, 0, 4, 4);
        add(1, 1000, 1, 0, 0, 16'hFFFF, 1, 5, 4);
        // Refresh: 15 quiet PAUSED cycles, XOFF resent on the 16th.
        for (int k = 0; k < 15; k++) add(1, 1000, 1, 0, 0, 16'hFFFF, 1, 5, 4);
        add(1, 1000, 1, 0, 1, 16'hFFFF, 1, 5, 4);
        add(1, 1000, 1, 0, 0, 16'hFFFF, 1, 6, 4);
        // Level drops on the refresh cycle: XON wins.
        for (int k = 0; k < 15; k++) add(1, 1000, 1, 0, 0, 16'hFFFF, 1, 6, 4);
        add(1, 200,  1, 0, 1, 16'h0000, 1, 6, 4);
        add(1, 200,  1, 0, 0, 16'h0000, 0, 6, 5);

        foreach (tbl[i]) begin
            drive(tbl[i].en, int'(tbl[i].lvl), tbl[i].rdy, tbl[i].clr);
            tick();
            chk($sformatf("row%0d tvalid", i), 32'(s_axi_nfc_tvalid), 32'(tbl[i].vld));
            if (tbl[i].vld)
                chk($sformatf("row%0d tdata", i), 32'(s_axi_nfc_tdata), 32'(tbl[i].data));
            chk($sformatf("row%0d paused", i), 32'(paused), 32'(tbl[i].psd));
            chk($sformatf("row%0d xoff_count", i), 32'(xoff_count), 32'(tbl[i].xoff));
            chk($sformatf("row%0d xon_count", i), 32'(xon_count), 32'(tbl[i].xon));
        end
        chk("level_max after table", 32'(level_max), 32'd1000);

        // clear_stats coinciding with an XOFF handshake.
        drive(1'b1, 900, 1'b1, 1'b0);
        tick();
        chk("clr seq tvalid", 32'(s_axi_nfc_tvalid), 32'd1);
        drive(1'b1, 900, 1'b1, 1'b1);
        tick();
        chk("clr+hs xoff_count", 32'(xoff_count), 32'd1);
        chk("clr xon_count", 32'(xon_count), 32'd0);
        chk("clr level_max", 32'(level_max), 32'd900);
        chk("clr+hs paused", 32'(paused), 32'd1);
        drive(1'b1, 100, 1'b1, 1'b0);
        tick();
        chk("post clr xon tdata", 32'(s_axi_nfc_tdata), 32'h0000);
        tick();
        chk("post clr xon_count", 32'(xon_count), 32'd1);

        // Counter saturation at all-ones (4-bit counters here).
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 900, 1'b1, 1'b0);
            tick();
            tick();
            drive(1'b1, 100, 1'b1, 1'b0);
            tick();
            tick();
        end
        chk("sat xoff_count", 32'(xoff_count), 32'd15);
        chk("sat xon_count", 32'(xon_count), 32'd15);
        chk("sat paused", 32'(paused), 32'd0);
        chk("sat level_max", 32'(level_max), 32'd900);

        // Reset pulsed mid-handshake with a high level.
        drive(1'b1, 950, 1'b0, 1'b0);
        tick();
        chk("pre-rst tvalid", 32'(s_axi_nfc_tvalid), 32'd1);
        chk("pre-rst level_max", 32'(level_max), 32'd950);
        tick();
        chk("stalled tvalid", 32'(s_axi_nfc_tvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst tvalid", 32'(s_axi_nfc_tvalid), 32'd0);
        chk("async rst tdata", 32'(s_axi_nfc_tdata), 32'd0);
        chk("async rst xoff_count", 32'(xoff_count), 32'd0);
        chk("async rst level_max", 32'(level_max), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post-rst tvalid", 32'(s_axi_nfc_tvalid), 32'd1);
        chk("post-rst tdata", 32'(s_axi_nfc_tdata), 32'hFFFF);
        chk("post-rst paused", 32'(paused), 32'd0);
        drive(1'b1, 950, 1'b1, 1'b0);
        tick();
        chk("post-rst hs tvalid", 32'(s_axi_nfc_tvalid), 32'd0);
        chk("post-rst hs paused", 32'(paused), 32'd1);
        chk("post-rst xoff_count", 32'(xoff_count), 32'd1);
        chk("post-rst level_max", 32'(level_max), 32'd950);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
